// File: rtl/imem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter_if
//   Bundles the fetch, data and byte-wide memory signals of the instruction
//   memory port arbiter.
//   slave  : the arbiter (consumes requests and mem_dataout, drives grants,
//            results and the memory address/write strobe).
//   master : the surrounding core / memory model.
//   Fetch : f_req, f_addr[31:0] -> f_grant, f_rdata[7:0]
//   Data  : d_req, d_we, d_addr[31:0], d_size[1:0], d_wdata[31:0]
//           -> d_rdata[31:0], d_busy, d_done
//   Mem   : mem_addr[31:0], mem_we, mem_datain[7:0] -> mem_dataout[7:0]
// ---------------------------------------------------------------------------
interface imem_port_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_grant;
    logic [7:0]  f_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_busy;
    logic        d_done;

    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_datain;
    logic [7:0]  mem_dataout;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_size, d_wdata, mem_dataout,
        output f_grant, f_rdata, d_rdata, d_busy, d_done, mem_addr, mem_we, mem_datain
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_size, d_wdata, mem_dataout,
        input  f_grant, f_rdata, d_rdata, d_busy, d_done, mem_addr, mem_we, mem_datain
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// ---------------------------------------------------------------------------
// imem_port_arbiter
//   Shares one byte-wide memory port between instruction fetch and a data
//   side that moves 1..4 bytes (any alignment) one byte per cycle.
//   Data accesses take priority: while bytes are moving, fetch is stalled
//   (f_grant=0); otherwise fetch owns the port and mem_addr follows f_addr.
//
//   Ports:
//     clk     - clock, rising edge
//     resetn  - asynchronous active-low reset
//     bus     - imem_port_arbiter_if.slave (fetch, data and memory signals)
//
//   Build option:
//     ARB_STORE_EN - when defined, d_we selects stores that drive mem_we and
//                    mem_datain. When undefined, d_we/d_wdata are ignored,
//                    mem_we/mem_datain are tied 0 and every access is a load.
// ---------------------------------------------------------------------------
module imem_port_arbiter (
    input  logic                 clk,
    input  logic                 resetn,
    imem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic        done_q;
    logic        we_q;
    logic [31:0] wdata_q;

    // Request fields as the FSM latches them; store fields collapse to 0
    // when the store path is not built.
    logic        we_d;
    logic [31:0] wdata_d;

`ifdef ARB_STORE_EN
    assign we_d    = bus.d_we;
    assign wdata_d = bus.d_wdata;
`else
    assign we_d    = 1'b0;
    assign wdata_d = 32'h0;
    logic unused_store_inputs;
    assign unused_store_inputs = &{1'b0, bus.d_we, bus.d_wdata};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            rdata_q <= 32'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.d_req) begin
                        addr_q  <= bus.d_addr;
                        size_q  <= bus.d_size;
                        we_q    <= we_d;
                        wdata_q <= wdata_d;
                        cnt_q   <= 2'd0;
                        // Loads start from zero so lanes past the size read as 0.
                        if (!we_d)
                            rdata_q <= 32'h0;
                        busy_q  <= 1'b1;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (!we_q)
                        rdata_q[{cnt_q, 3'b000} +: 8] <= bus.mem_dataout;
                    if (cnt_q == size_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic in_xfer;
    assign in_xfer = (state_q == XFER);

    // Byte address wraps naturally in 32 bits.
    assign bus.mem_addr = in_xfer ? (addr_q + {30'h0, cnt_q}) : bus.f_addr;
    assign bus.f_grant  = bus.f_req & ~in_xfer;
    assign bus.f_rdata  = bus.mem_dataout;
    assign bus.d_rdata  = rdata_q;
    assign bus.d_busy   = busy_q;
    assign bus.d_done   = done_q;

`ifdef ARB_STORE_EN
    assign bus.mem_we     = in_xfer & we_q;
    assign bus.mem_datain = (in_xfer & we_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
`else
    assign bus.mem_we     = 1'b0;
    assign bus.mem_datain = 8'h00;
    logic unused_store_state;
    assign unused_store_state = &{1'b0, wdata_q};
`endif

endmodule
